// File: rtl/note_scheduler.sv
`timescale 1ns/1ps
// note_scheduler: three-lane falling-note game core for two players taking turns.
// Notes spawn from an 8-entry pattern ROM on beat ticks, fall on frame ticks,
// and are scored when the matching lane button is pressed inside the hit window.
module note_scheduler #(
  parameter int SPEED  = 2,
  parameter int HIT_LO = 420,
  parameter int HIT_HI = 460,
  parameter int Y_MAX  = 479,
  parameter int BEATS  = 16
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       beat_tick,
  input  logic [2:0] btn,
  output logic [2:0] lane_act,
  output logic [9:0] lane_y_r,
  output logic [9:0] lane_y_g,
  output logic [9:0] lane_y_b,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY1 = 2'b01,
    S_PLAY2 = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] L_BEATS  = CNT_W'(BEATS);
  localparam logic [10:0]      L_SPEED  = 11'(SPEED);
  localparam logic [10:0]      L_HIT_LO = 11'(HIT_LO);
  localparam logic [10:0]      L_HIT_HI = 11'(HIT_HI);
  localparam logic [10:0]      L_Y_MAX  = 11'(Y_MAX);

  // Lane index 0 = B, 1 = G, 2 = R, matching the {R,G,B} bit order of btn/lane_act.
  state_t           r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [2:0]       r_ptr;
  logic [2:0]       r_btn_prev;
  logic [2:0]       r_valid;
  logic [2:0][9:0]  r_y;
  logic [3:0]       r_p1;
  logic [3:0]       r_p2;

  logic [2:0]       w_rom;
  logic             w_play;
  logic             w_beat_ok;
  logic [2:0]       w_press;
  logic [2:0]       w_hit;
  logic [2:0]       w_spawn;
  logic [2:0]       w_valid_next;
  logic [2:0][9:0]  w_y_next;
  logic [2:0][10:0] w_y_moved;
  logic [2:0]       w_hit_cnt;
  logic [3:0]       w_score_cur;
  logic [4:0]       w_score_sum;
  logic [3:0]       w_score_sat;

  // Spawn pattern ROM, one {R,G,B} entry per beat.
  always_comb begin
    w_rom = 3'b000;
    case (r_ptr)
      3'd0: w_rom = 3'b000;
      3'd1: w_rom = 3'b001;
      3'd2: w_rom = 3'b010;
      3'd3: w_rom = 3'b100;
      3'd4: w_rom = 3'b001;
      3'd5: w_rom = 3'b010;
      3'd6: w_rom = 3'b100;
      3'd7: w_rom = 3'b111;
      default: w_rom = 3'b000;
    endcase
  end

  assign w_play    = (r_state == S_PLAY1) || (r_state == S_PLAY2);
  assign w_beat_ok = w_play && beat_tick && (r_beat_cnt < L_BEATS);
  assign w_press   = btn & ~r_btn_prev;

  // Per-lane next state: a hit clears (judged on pre-move y, so it beats motion),
  // a spawn only fills an empty lane, otherwise the note falls and may miss.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic w_in_win;
    assign w_in_win      = ({1'b0, r_y[gi]} >= L_HIT_LO) && ({1'b0, r_y[gi]} <= L_HIT_HI);
    assign w_hit[gi]     = w_play && w_press[gi] && r_valid[gi] && w_in_win;
    assign w_spawn[gi]   = w_beat_ok && w_rom[gi] && !r_valid[gi];
    assign w_y_moved[gi] = {1'b0, r_y[gi]} + L_SPEED;
    assign w_valid_next[gi] = w_hit[gi]                    ? 1'b0 :
                              w_spawn[gi]                  ? 1'b1 :
                              (r_valid[gi] && frame_tick)  ? (w_y_moved[gi] <= L_Y_MAX) :
                                                             r_valid[gi];
    assign w_y_next[gi] = w_spawn[gi]                              ? 10'd0 :
                          (r_valid[gi] && frame_tick && !w_hit[gi]) ? w_y_moved[gi][9:0] :
                                                                     r_y[gi];
  end

  // Simultaneous hits all count; the active player's score saturates at 10.
  assign w_hit_cnt   = {2'b00, w_hit[0]} + {2'b00, w_hit[1]} + {2'b00, w_hit[2]};
  assign w_score_cur = (r_state == S_PLAY2) ? r_p2 : r_p1;
  assign w_score_sum = {1'b0, w_score_cur} + {2'b00, w_hit_cnt};
  assign w_score_sat = (w_score_sum > 5'd10) ? 4'd10 : w_score_sum[3:0];

  // Game FSM with lane, score, beat and pattern state.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_ptr      <= 3'd0;
      r_btn_prev <= 3'b000;
      r_valid    <= 3'b000;
      r_y        <= '0;
      r_p1       <= 4'd0;
      r_p2       <= 4'd0;
    end else begin
      r_btn_prev <= btn;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_PLAY1;
            r_beat_cnt <= '0;
            r_ptr      <= 3'd0;
            r_valid    <= 3'b000;
            r_y        <= '0;
            r_p1       <= 4'd0;
            r_p2       <= 4'd0;
          end
        end
        S_PLAY1, S_PLAY2: begin
          r_valid <= w_valid_next;
          r_y     <= w_y_next;
          if (r_state == S_PLAY1) r_p1 <= w_score_sat;
          else                    r_p2 <= w_score_sat;
          if (w_beat_ok) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            r_ptr      <= r_ptr + 3'd1;
          end
          // Turn ends once every beat has been issued and the board is empty.
          if ((r_beat_cnt == L_BEATS) && (r_valid == 3'b000)) begin
            r_state    <= (r_state == S_PLAY1) ? S_PLAY2 : S_DONE;
            r_beat_cnt <= '0;
            r_ptr      <= 3'd0;
          end
        end
        S_DONE: begin
          if (!start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lane_act = r_valid;
  assign lane_y_b = r_y[0];
  assign lane_y_g = r_y[1];
  assign lane_y_r = r_y[2];
  assign p1_score = r_p1;
  assign p2_score = r_p2;
  assign state    = r_state;

endmodule

// File: tb/tb_note_scheduler.sv
`timescale 1ns/1ps
// Directed-vector bench for note_scheduler: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_note_scheduler;

  logic       board_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       beat_tick = 1'b0;
  logic [2:0] btn = 3'b000;
  logic [2:0] lane_act;
  logic [9:0] lane_y_r, lane_y_g, lane_y_b;
  logic [3:0] p1_score, p2_score;
  logic [1:0] state;

  note_scheduler dut (
    .board_clk (board_clk),
    .reset     (reset),
    .start     (start),
    .frame_tick(frame_tick),
    .beat_tick (beat_tick),
    .btn       (btn),
    .lane_act  (lane_act),
    .lane_y_r  (lane_y_r),
    .lane_y_g  (lane_y_g),
    .lane_y_b  (lane_y_b),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .state     (state)
  );

  always #5 board_clk = ~board_clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [2:0] act;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [2:0] ymask;
    logic [9:0] yr;
    logic [9:0] yg;
    logic [9:0] yb;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  logic start_lvl = 1'b0;

  task automatic expect_out(input string name, input logic [1:0] st, input logic [2:0] act,
                            input logic [3:0] s1, input logic [3:0] s2, input logic [2:0] ymask,
                            input logic [9:0] yr, input logic [9:0] yg, input logic [9:0] yb);
    exp_t e;
    e.name = name; e.st = st; e.act = act; e.s1 = s1; e.s2 = s2;
    e.ymask = ymask; e.yr = yr; e.yg = yg; e.yb = yb;
    sb_q.push_back(e);
  endtask

  // One clock of stimulus; returns 1 time unit after the active edge.
  task automatic tick(input logic fr, input logic bt, input logic [2:0] b);
    start = start_lvl; frame_tick = fr; beat_tick = bt; btn = b;
    @(posedge board_clk); #1;
    frame_tick = 1'b0; beat_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 3'b000);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 3'b000);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge board_clk) begin
    exp_t e;
    logic ok;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      ok = (state === e.st) && (lane_act === e.act) && (p1_score === e.s1) && (p2_score === e.s2)
        && (!e.ymask[2] || (lane_y_r === e.yr))
        && (!e.ymask[1] || (lane_y_g === e.yg))
        && (!e.ymask[0] || (lane_y_b === e.yb));
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s: got st=%b act=%b y=%0d/%0d/%0d p1=%0d p2=%0d, want st=%b act=%b y=%0d/%0d/%0d (mask %b) p1=%0d p2=%0d",
                 e.name, state, lane_act, lane_y_r, lane_y_g, lane_y_b, p1_score, p2_score,
                 e.st, e.act, e.yr, e.yg, e.yb, e.ymask, e.s1, e.s2);
      end else begin
        $display("check %s ok: st=%b act=%b p1=%0d p2=%0d", e.name, state, lane_act, p1_score, p2_score);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(posedge board_clk); #1;
    expect_out("reset", 2'b00, 3'b000, 4'd0, 4'd0, 3'b111, 10'd0, 10'd0, 10'd0);
    @(posedge board_clk); #1;
    reset = 1'b0;
    tick(1'b0, 1'b0, 3'b000);
    expect_out("idle_hold", 2'b00, 3'b000, 4'd0, 4'd0, 3'b000, 10'd0, 10'd0, 10'd0);

    // Game 1, player 1
    start_lvl = 1'b1;
    tick(1'b0, 1'b0, 3'b000);
    expect_out("start", 2'b01, 3'b000, 4'd0, 4'd0, 3'b111, 10'd0, 10'd0, 10'd0);
    start_lvl = 1'b0;
    tick(1'b0, 1'b1, 3'b000);
    expect_out("beat_ptr0", 2'b01, 3'b000, 4'd0, 4'd0, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b1, 3'b000);
    expect_out("beat_ptr1", 2'b01, 3'b001, 4'd0, 4'd0, 3'b001, 10'd0, 10'd0, 10'd0);
    frames(100);
    tick(1'b0, 1'b0, 3'b001);
    expect_out("press_y200", 2'b01, 3'b001, 4'd0, 4'd0, 3'b001, 10'd0, 10'd0, 10'd200);
    tick(1'b0, 1'b0, 3'b000);
    frames(115);
    tick(1'b0, 1'b0, 3'b001);
    expect_out("hit_y430", 2'b01, 3'b000, 4'd1, 4'd0, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    tick(1'b0, 1'b1, 3'b000);                       // ptr2: G spawns
    tick(1'b1, 1'b1, 3'b000);                       // ptr3: R spawns with frame, G falls
    expect_out("spawn_on_frame", 2'b01, 3'b110, 4'd1, 4'd0, 3'b110, 10'd0, 10'd2, 10'd0);
    frames(5);                                      // R=10, G=12
    tick(1'b0, 1'b1, 3'b000);                       // ptr4: B spawns
    tick(1'b0, 1'b1, 3'b000);                       // ptr5: G occupied, dropped
    tick(1'b1, 1'b1, 3'b000);                       // ptr6: R occupied, all fall
    expect_out("occupied_no_respawn", 2'b01, 3'b111, 4'd1, 4'd0, 3'b111, 10'd12, 10'd14, 10'd2);
    frames(204);                                    // R=420, G=422, B=410
    tick(1'b0, 1'b0, 3'b110);
    expect_out("dual_hit", 2'b01, 3'b001, 4'd3, 4'd0, 3'b001, 10'd0, 10'd0, 10'd410);
    tick(1'b0, 1'b0, 3'b000);
    frames(5);                                      // B=420
    tick(1'b1, 1'b0, 3'b001);
    expect_out("hit_with_frame", 2'b01, 3'b000, 4'd4, 4'd0, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    tick(1'b0, 1'b1, 3'b000);                       // ptr7: all three spawn
    frames(239);
    expect_out("y478_alive", 2'b01, 3'b111, 4'd4, 4'd0, 3'b111, 10'd478, 10'd478, 10'd478);
    frames(1);
    expect_out("miss_y480", 2'b01, 3'b000, 4'd4, 4'd0, 3'b000, 10'd0, 10'd0, 10'd0);
    beats(8);
    expect_out("beats_16", 2'b01, 3'b111, 4'd4, 4'd0, 3'b111, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b1, 3'b000);                       // beyond BEATS: ignored
    expect_out("beat_ignored", 2'b01, 3'b111, 4'd4, 4'd0, 3'b111, 10'd0, 10'd0, 10'd0);
    frames(240);
    expect_out("miss_all", 2'b01, 3'b000, 4'd4, 4'd0, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    expect_out("to_play2", 2'b10, 3'b000, 4'd4, 4'd0, 3'b000, 10'd0, 10'd0, 10'd0);

    // Game 1, player 2
    beats(4); frames(215);
    tick(1'b0, 1'b0, 3'b111);
    expect_out("triple_hit", 2'b10, 3'b000, 4'd4, 4'd3, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    beats(3); frames(215);
    tick(1'b0, 1'b0, 3'b111);
    expect_out("p2_6", 2'b10, 3'b000, 4'd4, 4'd6, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    tick(1'b0, 1'b1, 3'b000); frames(215);
    tick(1'b0, 1'b0, 3'b111);
    expect_out("p2_9", 2'b10, 3'b000, 4'd4, 4'd9, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    beats(4); frames(215);
    tick(1'b0, 1'b0, 3'b111);
    expect_out("saturate", 2'b10, 3'b000, 4'd4, 4'd10, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    beats(4); frames(240);
    expect_out("miss_p2", 2'b10, 3'b000, 4'd4, 4'd10, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    expect_out("done", 2'b11, 3'b000, 4'd4, 4'd10, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    expect_out("idle_again", 2'b00, 3'b000, 4'd4, 4'd10, 3'b000, 10'd0, 10'd0, 10'd0);

    // Game 2: start held high throughout play
    start_lvl = 1'b1;
    tick(1'b0, 1'b0, 3'b000);
    expect_out("restart", 2'b01, 3'b000, 4'd0, 4'd0, 3'b000, 10'd0, 10'd0, 10'd0);
    beats(16); frames(240);
    tick(1'b0, 1'b0, 3'b000);
    expect_out("g2_play2", 2'b10, 3'b000, 4'd0, 4'd0, 3'b000, 10'd0, 10'd0, 10'd0);
    beats(4); frames(215);
    tick(1'b0, 1'b0, 3'b111);
    tick(1'b0, 1'b0, 3'b000);
    beats(2); frames(215);
    tick(1'b0, 1'b0, 3'b011);
    expect_out("p2_5", 2'b10, 3'b000, 4'd0, 4'd5, 3'b000, 10'd0, 10'd0, 10'd0);
    tick(1'b0, 1'b0, 3'b000);
    tick(1'b0, 1'b1, 3'b000);                       // ptr6: R spawns
    frames(100);                                    // R=200
    tick(1'b0, 1'b1, 3'b000);                       // ptr7: G,B spawn, R dropped
    frames(140);                                    // R reaches 480 and clears, G=B=280
    expect_out("pre_reset", 2'b10, 3'b011, 4'd0, 4'd5, 3'b011, 10'd0, 10'd280, 10'd280);

    // Asynchronous reset between clock edges
    start_lvl = 1'b0;
    start = 1'b0;
    @(negedge board_clk);
    @(posedge board_clk); #2;
    reset = 1'b1;
    #1;
    expect_out("async_reset", 2'b00, 3'b000, 4'd0, 4'd0, 3'b111, 10'd0, 10'd0, 10'd0);
    @(posedge board_clk); #1;
    @(posedge board_clk); #1;
    reset = 1'b0;
    tick(1'b0, 1'b0, 3'b000);
    expect_out("post_reset", 2'b00, 3'b000, 4'd0, 4'd0, 3'b111, 10'd0, 10'd0, 10'd0);

    repeat (2) @(negedge board_clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
